arbitro_contador: RTL and testbench
===================================

# arbitro_contador

Round-robin arbiter and sequencer that shares one 4-bit `contador` counter between two requesters. Each requester posts a job: an operation mode, a load value and a run length. The block grants one job at a time and drives the counter's `enable`, `mode` and `D` for exactly the job's duration. It counts `rco` wrap events and reports completion with the winning requester's ID and the wrap count. It sits between the requester logic and a single `contador` instance.

## Interface

Parameters: none. All widths are fixed by the `contador` interface.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  requester 0 has a job; held until `req0_ready` is seen
- `req0_op`  in  2  requester 0 counter mode
- `req0_d`  in  4  requester 0 load value
- `req0_len`  in  4  requester 0 run length; enabled cycles = `len`+1
- `req0_ready`  out  1  one-cycle accept pulse for requester 0
- `req1_valid`, `req1_op`, `req1_d`, `req1_len`, `req1_ready`: same as requester 0, for requester 1
- `enable`  out  1  to counter `enable`
- `mode`  out  2  to counter `mode`
- `D`  out  4  to counter `D`
- `rco`  in  1  from counter ripple-carry-out
- `busy`  out  1  a job is in progress (state RUN or DONE)
- `done`  out  1  one-cycle job-complete pulse
- `done_id`  out  1  requester of the completed job
- `wraps`  out  5  number of `rco` samples during the completed job

## Operation

Mode encoding is passed through unchanged:
- 00: count up by 3
- 01: count down by 1
- 10: count up by 1
- 11: parallel load `D`

All outputs are registered. FSM states:
- **IDLE**
  - No valid request: remain in IDLE.
  - Any valid request: select a winner and capture its `op`, `d`, `len` at this edge. Go to RUN.
  - Winner's `readyN` = 1 for the first RUN cycle only.
- **Arbitration (round-robin)**
  - Pointer `last` records the most recent winner; reset value is 1, so requester 0 wins the first tie.
  - If both requesters are valid, the one that is not `last` wins. If only one is valid, it wins.
  - `last` updates at grant.
- **RUN**
  - Outputs: `enable`=1, `mode`=captured op, `D`=captured d.
  - Remaining-cycle counter is loaded with `len` at grant. It decrements each RUN edge; RUN exits at the edge where it equals 0.
  - Op 11 (load): RUN lasts exactly 1 cycle; `len` is ignored.
  - `wraps` accumulator clears at grant and increments on each RUN edge that samples `rco`=1. Maximum 16, so no overflow.
- **DONE**
  - Outputs: `enable`=0, `done`=1, `done_id`=winner, `wraps`=accumulated count. Go to IDLE.
- Outside RUN: `enable`=0, `mode`=00, `D`=0.
- Outside DONE: `done`=0. `done_id` and `wraps` hold their last values.
- `valid` and the job fields must be stable from assertion until `ready`. A `valid` still high when the FSM returns to IDLE is treated as a new job.
- Reset (`reset`=0, any time, including mid-RUN):
  - State goes to IDLE and `last`=1.
  - All outputs go to 0 immediately; no `done` is issued for the aborted job.

## Timing

- Edge E0 samples `valid` in IDLE. `ready` is high during cycle 1.
- RUN occupies cycles 1..N, where N = `len`+1, or N = 1 for a load.
- DONE occupies cycle N+1 and IDLE occupies cycle N+2. The earliest next grant is the edge ending cycle N+2.
- Throughput: one job per N+2 cycles.
- `enable` is high for exactly N cycles per job, which gives N counter updates.
- `busy` is high during cycles 1..N+1.
- Release of reset takes effect at the first rising edge after deassertion.

## Test plan

1. **Reset:** assert `reset`=0 with requests pending. Required: all outputs 0. After release with no requests, FSM stays IDLE and `enable` stays 0.
2. **Load:** `req0` op=11, d=14, len=9. Required: `req0_ready` pulses in cycle 1; `enable` high for 1 cycle with `mode`=11, `D`=14; counter Q=14. `done`=1 in cycle 2 with `done_id`=0, `wraps`=0.
3. **Count with wrap:** after step 2, `req0` op=10, len=3. Required: `enable` high for 4 cycles; Q goes 14→15→0→1→2; `wraps`=1 (counter model asserts `rco` once per wrap); `done` pulses in cycle 5.
4. **Tie fairness:** both requesters hold `valid` continuously with op=10, len=0. Required: grants alternate 0,1,0,1. Each job gives 1 `enable` cycle and a 3-cycle period; `done_id` sequence is 0,1,0,1.
5. **Single requester:** `req1` only, repeated. Required: `req1` is served every time despite `last`=1; `req0_ready` never pulses.
6. **Reset mid-RUN:** `req1` op=01, len=15; assert reset in the 5th RUN cycle. Required: `enable` falls asynchronously and no `done` is issued. After release with both requesters valid, `req0` wins first.

Source files
------------

// File: rtl/arbitro_contador_if.sv
// Interface: requester handshakes, counter control/feedback and job status for arbitro_contador.
// Ports: two requester channels (req*_valid/op/d/len/ready), counter side (enable/mode/D/rco),
//        status (busy/done/done_id/wraps). master = requester/counter side, slave = arbiter.
interface arbitro_contador_if;
   logic       req0_valid;
   logic [1:0] req0_op;
   logic [3:0] req0_d;
   logic [3:0] req0_len;
   logic       req0_ready;
   logic       req1_valid;
   logic [1:0] req1_op;
   logic [3:0] req1_d;
   logic [3:0] req1_len;
   logic       req1_ready;
   logic       enable;
   logic [1:0] mode;
   logic [3:0] D;
   logic       rco;
   logic       busy;
   logic       done;
   logic       done_id;
   logic [4:0] wraps;

   modport master (
      output req0_valid, req0_op, req0_d, req0_len,
      output req1_valid, req1_op, req1_d, req1_len,
      output rco,
      input  req0_ready, req1_ready,
      input  enable, mode, D,
      input  busy, done, done_id, wraps
   );

   modport slave (
      input  req0_valid, req0_op, req0_d, req0_len,
      input  req1_valid, req1_op, req1_d, req1_len,
      input  rco,
      output req0_ready, req1_ready,
      output enable, mode, D,
      output busy, done, done_id, wraps
   );
endinterface

// File: rtl/arbitro_contador.sv
// Round-robin arbiter/sequencer sharing one 4-bit counter between two requesters.
// Ports: clk, reset (async active-low), bus (slave modport: requests, counter control, status).
// Latency: grant at the IDLE edge seeing valid; RUN len+1 cycles (1 for load), then one DONE cycle.
module arbitro_contador (
   input  logic               clk,
   input  logic               reset,
   arbitro_contador_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state, state_nx;
   logic       last, last_nx;
   logic       winner, winner_nx;
   logic [3:0] rem, rem_nx;
   logic [4:0] acc, acc_nx;

   // Registered outputs; mode_q/D_q double as the captured job fields while in RUN.
   logic       ready0_q, ready0_nx;
   logic       ready1_q, ready1_nx;
   logic       enable_q, enable_nx;
   logic [1:0] mode_q, mode_nx;
   logic [3:0] d_q, d_nx;
   logic       busy_q, busy_nx;
   logic       done_q, done_nx;
   logic       done_id_q, done_id_nx;
   logic [4:0] wraps_q, wraps_nx;

   logic       pick;
   logic [1:0] pick_op;

   // On a tie the requester that did not win last time is served; otherwise the lone requester.
   assign pick    = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
   assign pick_op = pick ? bus.req1_op : bus.req0_op;

   always_comb begin
      state_nx   = state;
      last_nx    = last;
      winner_nx  = winner;
      rem_nx     = rem;
      acc_nx     = acc;
      ready0_nx  = 1'b0;
      ready1_nx  = 1'b0;
      enable_nx  = 1'b0;
      mode_nx    = 2'b00;
      d_nx       = 4'd0;
      busy_nx    = 1'b0;
      done_nx    = 1'b0;
      done_id_nx = done_id_q;
      wraps_nx   = wraps_q;
      case (state)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               state_nx  = RUN;
               winner_nx = pick;
               last_nx   = pick;
               enable_nx = 1'b1;
               mode_nx   = pick_op;
               d_nx      = pick ? bus.req1_d : bus.req0_d;
               // A load needs a single counter update, so its length is forced to zero.
               rem_nx    = (pick_op == 2'b11) ? 4'd0 : (pick ? bus.req1_len : bus.req0_len);
               acc_nx    = 5'd0;
               busy_nx   = 1'b1;
               ready0_nx = ~pick;
               ready1_nx = pick;
            end
         end
         RUN: begin
            acc_nx  = acc + {4'd0, bus.rco};
            busy_nx = 1'b1;
            if (rem == 4'd0) begin
               state_nx   = DONE;
               done_nx    = 1'b1;
               done_id_nx = winner;
               wraps_nx   = acc + {4'd0, bus.rco};
            end else begin
               rem_nx    = rem - 4'd1;
               enable_nx = 1'b1;
               mode_nx   = mode_q;
               d_nx      = d_q;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         winner    <= 1'b0;
         rem       <= 4'd0;
         acc       <= 5'd0;
         ready0_q  <= 1'b0;
         ready1_q  <= 1'b0;
         enable_q  <= 1'b0;
         mode_q    <= 2'b00;
         d_q       <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         wraps_q   <= 5'd0;
      end else begin
         state     <= state_nx;
         last      <= last_nx;
         winner    <= winner_nx;
         rem       <= rem_nx;
         acc       <= acc_nx;
         ready0_q  <= ready0_nx;
         ready1_q  <= ready1_nx;
         enable_q  <= enable_nx;
         mode_q    <= mode_nx;
         d_q       <= d_nx;
         busy_q    <= busy_nx;
         done_q    <= done_nx;
         done_id_q <= done_id_nx;
         wraps_q   <= wraps_nx;
      end
   end

   assign bus.req0_ready = ready0_q;
   assign bus.req1_ready = ready1_q;
   assign bus.enable     = enable_q;
   assign bus.mode       = mode_q;
   assign bus.D          = d_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.done_id    = done_id_q;
   assign bus.wraps      = wraps_q;

endmodule

// File: tb/tb_arbitro_contador.sv
// Testbench for arbitro_contador: directed jobs driving a behavioural contador model,
// a job-timeline reference model checked every cycle, and literal per-scenario expectations.
module tb_arbitro_contador;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arbitro_contador_if b();
   arbitro_contador dut (.clk(clk), .reset(reset), .bus(b));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- contador model (Q register, combinational rco on wrap) ----------------
   logic [3:0] q = 4'd0;

   function automatic logic wrap_f(input logic en, input logic [1:0] md, input logic [3:0] qq);
      if (!en) return 1'b0;
      case (md)
         2'b00:   return (qq >= 4'd13);
         2'b01:   return (qq == 4'd0);
         2'b10:   return (qq == 4'd15);
         default: return 1'b0;
      endcase
   endfunction

   assign b.rco = wrap_f(b.enable, b.mode, q);

   always @(posedge clk)
      if (b.enable)
         case (b.mode)
            2'b00:   q <= q + 4'd3;
            2'b01:   q <= q - 4'd1;
            2'b10:   q <= q + 4'd1;
            default: q <= b.D;
         endcase

   // ---------------- reference model: position within the current job ----------------
   // m_t counts cycles since the grant (1 = first enabled cycle); m_n is the job's enabled length.
   logic       m_active;
   int         m_t, m_n, m_acc;
   logic       m_id, m_last, m_done_id;
   logic [1:0] m_op;
   logic [3:0] m_d;
   logic [4:0] m_wraps;

   logic       m_pick;
   logic       e_en, e_r0, e_r1, e_busy, e_done, e_rco;
   logic [1:0] e_mode;
   logic [3:0] e_d;

   assign m_pick = (b.req0_valid && b.req1_valid) ? ~m_last : b.req1_valid;
   assign e_en   = m_active && (m_t <= m_n);
   assign e_mode = e_en ? m_op : 2'b00;
   assign e_d    = e_en ? m_d : 4'd0;
   assign e_r0   = m_active && (m_t == 1) && (m_id == 1'b0);
   assign e_r1   = m_active && (m_t == 1) && (m_id == 1'b1);
   assign e_busy = m_active;
   assign e_done = m_active && (m_t == m_n + 1);
   assign e_rco  = wrap_f(e_en, e_mode, q);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active <= 1'b0; m_t <= 0; m_n <= 0; m_acc <= 0;
         m_id <= 1'b0; m_last <= 1'b1; m_done_id <= 1'b0;
         m_op <= 2'b00; m_d <= 4'd0; m_wraps <= 5'd0;
      end else if (!m_active) begin
         if (b.req0_valid || b.req1_valid) begin
            m_active <= 1'b1;
            m_t      <= 1;
            m_id     <= m_pick;
            m_last   <= m_pick;
            m_op     <= m_pick ? b.req1_op : b.req0_op;
            m_d      <= m_pick ? b.req1_d  : b.req0_d;
            if ((m_pick ? b.req1_op : b.req0_op) == 2'b11) m_n <= 1;
            else m_n <= int'(m_pick ? b.req1_len : b.req0_len) + 1;
            m_acc    <= 0;
         end
      end else begin
         if (m_t <= m_n) m_acc <= m_acc + int'(e_rco);
         if (m_t == m_n) begin
            m_done_id <= m_id;
            m_wraps   <= 5'(m_acc + int'(e_rco));
         end
         if (m_t == m_n + 1) m_active <= 1'b0;
         else m_t <= m_t + 1;
      end
   end

   // Per-cycle comparison, sampled away from the clock edge.
   always @(posedge clk) begin
      #2;
      chk("req0_ready", b.req0_ready, e_r0);
      chk("req1_ready", b.req1_ready, e_r1);
      chk("enable", b.enable, e_en);
      chk("mode", b.mode, e_mode);
      chk("D", b.D, e_d);
      chk("busy", b.busy, e_busy);
      chk("done", b.done, e_done);
      chk("done_id", b.done_id, m_done_id);
      chk("wraps", b.wraps, m_wraps);
   end

   // Event counters
   int en_cnt = 0, r0_cnt = 0, done_cnt = 0;
   always @(negedge clk) begin
      if (b.enable)     en_cnt   <= en_cnt + 1;
      if (b.req0_ready) r0_cnt   <= r0_cnt + 1;
      if (b.done)       done_cnt <= done_cnt + 1;
   end

   task automatic set_req(input bit id, input logic v, input logic [1:0] op,
                          input logic [3:0] d, input logic [3:0] len);
      if (id) begin b.req1_valid = v; b.req1_op = op; b.req1_d = d; b.req1_len = len; end
      else    begin b.req0_valid = v; b.req0_op = op; b.req0_d = d; b.req0_len = len; end
   endtask

   // Post one job, wait for its accept and completion (both bounded).
   task automatic run_job(input bit id, input logic [1:0] op, input logic [3:0] d,
                          input logic [3:0] len, output logic gid, output logic [4:0] gw,
                          output int t_rdy, output int t_done);
      bit ok;
      set_req(id, 1'b1, op, d, len);
      ok = 0; t_rdy = 0; t_done = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (id ? b.req1_ready : b.req0_ready) begin ok = 1; t_rdy = cyc; end
      end
      chk("job_ready_seen", ok, 1);
      @(negedge clk);
      set_req(id, 1'b0, op, d, len);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (b.done) begin ok = 1; t_done = cyc; end
      end
      chk("job_done_seen", ok, 1);
      gid = b.done_id;
      gw  = b.wraps;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       gid;
      logic [4:0] gw;
      int         tr, td, e0, r0, d0, k;
      logic       ids [4];
      int         tc  [4];
      bit         ok;

      // ---- 1: reset with requests pending ----
      reset = 1'b0;
      set_req(0, 1'b1, 2'b10, 4'd3, 4'd2);
      set_req(1, 1'b1, 2'b01, 4'd7, 4'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_enable", b.enable, 0);
      chk("t1_busy", b.busy, 0);
      chk("t1_ready0", b.req0_ready, 0);
      chk("t1_done", b.done, 0);
      chk("t1_wraps", b.wraps, 0);
      @(negedge clk);
      set_req(0, 1'b0, 2'b00, 4'd0, 4'd0);
      set_req(1, 1'b0, 2'b00, 4'd0, 4'd0);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t1_idle_enable_cnt", en_cnt, 0);
      chk("t1_idle_busy", b.busy, 0);

      // ---- 2: load 14 ----
      e0 = en_cnt;
      run_job(0, 2'b11, 4'd14, 4'd9, gid, gw, tr, td);
      chk("t2_done_id", gid, 0);
      chk("t2_wraps", gw, 0);
      chk("t2_q", q, 14);
      chk("t2_enable_cycles", en_cnt - e0, 1);
      chk("t2_done_cycle", td - tr, 1);

      // ---- 3: count up 4 times through a wrap ----
      e0 = en_cnt;
      run_job(0, 2'b10, 4'd0, 4'd3, gid, gw, tr, td);
      chk("t3_done_id", gid, 0);
      chk("t3_wraps", gw, 1);
      chk("t3_q", q, 2);
      chk("t3_done_cycle", td - tr, 4);
      @(negedge clk);
      chk("t3_enable_cycles", en_cnt - e0, 4);

      // ---- 5: requester 1 alone, repeatedly ----
      r0 = r0_cnt;
      for (int j = 0; j < 3; j++) begin
         run_job(1, 2'b10, 4'd0, 4'd1, gid, gw, tr, td);
         chk("t5_done_id", gid, 1);
      end
      @(negedge clk);
      chk("t5_no_ready0", r0_cnt - r0, 0);

      // ---- 4: tie, both valid continuously ----
      @(negedge clk);
      e0 = en_cnt;
      set_req(0, 1'b1, 2'b10, 4'd0, 4'd0);
      set_req(1, 1'b1, 2'b10, 4'd0, 4'd0);
      k = 0;
      for (int i = 0; i < 60 && k < 4; i++) begin
         @(posedge clk); #1;
         if (b.done) begin ids[k] = b.done_id; tc[k] = cyc; k++; end
      end
      @(negedge clk);
      set_req(0, 1'b0, 2'b10, 4'd0, 4'd0);
      set_req(1, 1'b0, 2'b10, 4'd0, 4'd0);
      chk("t4_jobs", k, 4);
      if (k == 4) begin
         chk("t4_id0", ids[0], 0);
         chk("t4_id1", ids[1], 1);
         chk("t4_id2", ids[2], 0);
         chk("t4_id3", ids[3], 1);
         for (int j = 0; j < 3; j++) chk("t4_period", tc[j+1] - tc[j], 3);
      end
      chk("t4_enable_cycles", en_cnt - e0, 4);
      repeat (3) @(negedge clk);

      // ---- 6: reset in the 5th RUN cycle ----
      set_req(1, 1'b1, 2'b01, 4'd0, 4'd15);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (b.req1_ready) ok = 1;
      end
      chk("t6_ready1_seen", ok, 1);
      d0 = done_cnt;
      @(negedge clk);
      set_req(1, 1'b0, 2'b01, 4'd0, 4'd15);
      repeat (4) @(posedge clk);
      #2;
      chk("t6_enable_before", b.enable, 1);
      reset = 1'b0;
      #1;
      chk("t6_enable_async", b.enable, 0);
      chk("t6_busy_async", b.busy, 0);
      @(negedge clk);
      set_req(0, 1'b1, 2'b10, 4'd0, 4'd0);
      set_req(1, 1'b1, 2'b10, 4'd0, 4'd0);
      @(negedge clk);
      reset = 1'b1;
      chk("t6_no_done", done_cnt - d0, 0);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (b.req0_ready || b.req1_ready) ok = 1;
      end
      chk("t6_grant_seen", ok, 1);
      chk("t6_first_ready0", b.req0_ready, 1);
      chk("t6_first_ready1", b.req1_ready, 0);
      @(negedge clk);
      set_req(0, 1'b0, 2'b10, 4'd0, 4'd0);
      repeat (4) @(negedge clk);
      set_req(1, 1'b0, 2'b10, 4'd0, 4'd0);
      repeat (6) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
